arm_mc_controller: RTL and testbench

- Parametrised multicycle control unit for the ARM datapath; successor to the single-cycle controller.
- Sequences each instruction through a Moore FSM (fetch/decode/execute/memory/writeback), so one shared memory and ALU serve the whole datapath.
- Holds the architectural NZCV flags and the latched condition result.
- Adds a ready/request memory handshake for wait-state memories and the shift mode (shift_flag).

---
 rtl/arm_mc_pkg.sv | 64 ++++++
 rtl/arm_cond_check.sv | 37 +++
 rtl/arm_mc_controller.sv | 273 +++++++++++++++++++++++++++
 tb/tb_arm_mc_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the ARM multicycle control unit.
package arm_mc_pkg;

    // Controller sequencing states
    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'ha;
    localparam logic [3:0] COND_LT = 4'hb;
    localparam logic [3:0] COND_GT = 4'hc;
    localparam logic [3:0] COND_LE = 4'hd;
    localparam logic [3:0] COND_AL = 4'he;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Instruction class (Op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing cmd field values
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

endpackage

// File: rtl/arm_cond_check.sv
// Combinational condition evaluation: Cond field against NZCV flags.
module arm_cond_check
    import arm_mc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    // Evaluate the condition code; undefined code never executes
    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore sequencer plus instruction decode,
// NZCV flag register and optional memory ready handshake.
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ENABLE_SHIFT  = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        Instr,
    input  logic [3:0]         ALUFlags,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic               RegWrite,
    output logic [1:0]         ALUControl,
    output logic               shift_flag,
    output logic [STATE_W-1:0] state
);

    state_t     state_q;
    logic [3:0] flags_q;
    logic       condex_q;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       sbit;
    logic       ibit;
    logic       lbit;
    logic       rd_pc;
    logic       rdy;
    logic       condex;

    // Instr[3:0] carries fields consumed only by the datapath
    logic       unused_instr_lo;

    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign rd    = Instr[7:4];
    assign cmd   = funct[4:1];
    assign sbit  = funct[0];
    assign ibit  = funct[5];
    assign lbit  = funct[0];
    assign rd_pc = (rd == 4'hf);

    assign unused_instr_lo = ^Instr[3:0];

    // Without the handshake every access completes in its first cycle
    assign rdy = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

    arm_cond_check u_cond_check (
        .cond   (cond),
        .flags  (flags_q),
        .condex (condex)
    );

    logic [1:0] dp_alu;
    logic       dp_valid;
    logic       dp_nowrite;
    logic       dp_cv;
    logic       dp_shift;

    // Decode the data-processing cmd field
    always_comb begin
        dp_alu     = ALU_ADD;
        dp_valid   = 1'b0;
        dp_nowrite = 1'b1;
        dp_cv      = 1'b0;
        dp_shift   = 1'b0;
        case (cmd)
            CMD_ADD: begin
                dp_alu     = ALU_ADD;
                dp_valid   = 1'b1;
                dp_nowrite = 1'b0;
                dp_cv      = 1'b1;
            end
            CMD_SUB: begin
                dp_alu     = ALU_SUB;
                dp_valid   = 1'b1;
                dp_nowrite = 1'b0;
                dp_cv      = 1'b1;
            end
            CMD_AND: begin
                dp_alu     = ALU_AND;
                dp_valid   = 1'b1;
                dp_nowrite = 1'b0;
            end
            CMD_ORR: begin
                dp_alu     = ALU_ORR;
                dp_valid   = 1'b1;
                dp_nowrite = 1'b0;
            end
            CMD_CMP: begin
                dp_alu     = ALU_SUB;
                dp_valid   = 1'b1;
                dp_nowrite = 1'b1;
                dp_cv      = 1'b1;
            end
            CMD_MOV: begin
                // Shifter move: logical result only, C/V left alone
                if (ENABLE_SHIFT != 0) begin
                    dp_alu     = ALU_ADD;
                    dp_valid   = 1'b1;
                    dp_nowrite = 1'b0;
                    dp_shift   = 1'b1;
                end
            end
            default: begin
                dp_valid   = 1'b0;
                dp_nowrite = 1'b1;
            end
        endcase
    end

    // Sequencer, flag register and latched condition result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (rdy) state_q <= DECODE;
                end
                DECODE: begin
                    condex_q <= condex;
                    if (!condex) begin
                        state_q <= FETCH;
                    end else begin
                        case (op)
                            OP_MEM:  state_q <= MEMADR;
                            OP_BR:   state_q <= BRANCH;
                            OP_DP:   state_q <= ibit ? EXECI : EXECR;
                            default: state_q <= FETCH;
                        endcase
                    end
                end
                MEMADR: begin
                    state_q <= lbit ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    if (rdy) state_q <= MEMWB;
                end
                MEMWB: begin
                    state_q <= FETCH;
                end
                MEMWR: begin
                    if (rdy) state_q <= FETCH;
                end
                EXECR, EXECI: begin
                    // ALUFlags is valid now, so capture on the way out
                    if (sbit && dp_valid && condex_q) begin
                        flags_q[3:2] <= ALUFlags[3:2];
                        if (dp_cv) flags_q[1:0] <= ALUFlags[1:0];
                    end
                    state_q <= ALUWB;
                end
                ALUWB: begin
                    state_q <= FETCH;
                end
                BRANCH: begin
                    state_q <= FETCH;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    logic req_c;
    logic pcw_c;
    logic irw_c;
    logic memw_c;
    logic regw_c;

    // Moore control decode, qualified by instruction fields where needed
    always_comb begin
        req_c      = 1'b0;
        pcw_c      = 1'b0;
        irw_c      = 1'b0;
        memw_c     = 1'b0;
        regw_c     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        shift_flag = 1'b0;
        case (state_q)
            FETCH: begin
                req_c     = 1'b1;
                irw_c     = rdy;
                pcw_c     = rdy;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR: begin
                ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                req_c  = 1'b1;
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                regw_c    = condex_q;
                pcw_c     = condex_q & rd_pc;
            end
            MEMWR: begin
                req_c  = 1'b1;
                AdrSrc = 1'b1;
                memw_c = 1'b1;
            end
            EXECR: begin
                ALUSrcB    = SRCB_RD2;
                ALUControl = dp_alu;
                shift_flag = dp_shift;
            end
            EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dp_alu;
                shift_flag = dp_shift;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                regw_c    = condex_q & ~dp_nowrite;
                pcw_c     = condex_q & ~dp_nowrite & rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                pcw_c     = 1'b1;
            end
            default: begin
                req_c = 1'b0;
            end
        endcase
    end

    // Enables drop the moment reset asserts, independent of the clock
    assign mem_req  = req_c & reset;
    assign PCWrite  = pcw_c & reset;
    assign IRWrite  = irw_c & reset;
    assign MemWrite = memw_c & reset;
    assign RegWrite = regw_c & reset;

    assign ImmSrc = op;
    assign RegSrc = {(op == OP_MEM), (op == OP_BR)};
    assign state  = STATE_W'(state_q);

endmodule

// File: tb/tb_arm_mc_controller.sv
// Randomised and directed bench for arm_mc_controller against a
// phase-list reference model.
module tb_arm_mc_controller;
    import arm_mc_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       pcw;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] alu;
        logic       shf;
        logic [1:0] imm;
        logic [1:0] rsrc;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] instr = '0;
    logic [3:0]  aluflags = '0;
    logic        mr0 = 1'b1;
    logic        mr1 = 1'b1;

    logic       req0, pcw0, adr0, memw0, irw0, srca0, regw0, shf0;
    logic [1:0] res0, srcb0, imm0, rsrc0, alu0;
    logic [3:0] st0;
    logic       req1, pcw1, adr1, memw1, irw1, srca1, regw1, shf1;
    logic [1:0] res1, srcb1, imm1, rsrc1, alu1;
    logic [3:0] st1;

    obs_t obs0, obs1;
    assign obs0 = {st0, req0, pcw0, irw0, memw0, regw0, adr0, srca0, srcb0, res0, alu0, shf0,
                   imm0, rsrc0};
    assign obs1 = {st1, req1, pcw1, irw1, memw1, regw1, adr1, srca1, srcb1, res1, alu1, shf1,
                   imm1, rsrc1};

    arm_mc_controller #(.MEM_HANDSHAKE(1), .ENABLE_SHIFT(1), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(aluflags), .mem_ready(mr0),
        .mem_req(req0), .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(memw0), .IRWrite(irw0),
        .ResultSrc(res0), .ALUSrcA(srca0), .ALUSrcB(srcb0), .ImmSrc(imm0), .RegSrc(rsrc0),
        .RegWrite(regw0), .ALUControl(alu0), .shift_flag(shf0), .state(st0)
    );

    arm_mc_controller #(.MEM_HANDSHAKE(0), .ENABLE_SHIFT(0), .STATE_W(4)) dut_ns (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(aluflags), .mem_ready(mr1),
        .mem_req(req1), .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(memw1), .IRWrite(irw1),
        .ResultSrc(res1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .ImmSrc(imm1), .RegSrc(rsrc1),
        .RegWrite(regw1), .ALUControl(alu1), .shift_flag(shf1), .state(st1)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         sel = 0;
    logic [3:0] mflags [2];
    state_t     plan [$];

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !c || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ok: command executes; nw: no register write; cv: C/V captured; mv: shifter move
    task automatic cmd_info(input logic [3:0] cmd, input bit shen, output logic ok,
                            output logic nw, output logic cv, output logic mv,
                            output logic [1:0] alu);
        ok = 1; nw = 0; cv = 0; mv = 0; alu = 2'b00;
        case (cmd)
            4'b0100: cv = 1;
            4'b0010: begin alu = 2'b01; cv = 1; end
            4'b0000: alu = 2'b10;
            4'b1100: alu = 2'b11;
            4'b1010: begin alu = 2'b01; cv = 1; nw = 1; end
            4'b1101: begin
                if (shen) mv = 1;
                else begin ok = 0; nw = 1; end
            end
            default: begin ok = 0; nw = 1; end
        endcase
    endtask

    task automatic expect_for(input state_t s, input logic [19:0] ins, input logic rdy,
                              input bit shen, output obs_t e, output obs_t m);
        logic [1:0] op;
        logic       ok, nw, cv, mv;
        logic [1:0] alu;
        logic       rd15;
        op   = ins[15:14];
        rd15 = (ins[7:4] == 4'hf);
        cmd_info(ins[12:9], shen, ok, nw, cv, mv, alu);
        e = '0;
        m = '0;
        m.st = '1; e.st = 4'(s);
        m.req = 1; m.pcw = 1; m.irw = 1; m.memw = 1; m.regw = 1; m.shf = 1;
        m.imm = '1; m.rsrc = '1;
        e.imm = op;
        e.rsrc = {op == 2'b01, op == 2'b10};
        case (s)
            FETCH: begin
                e.req = 1; e.pcw = rdy; e.irw = rdy;
                m.adr = 1; m.srca = 1; e.srca = 1; m.srcb = '1; e.srcb = 2'b10;
                m.alu = '1; m.res = '1; e.res = 2'b10;
            end
            DECODE: begin
                m.srca = 1; e.srca = 1; m.srcb = '1; e.srcb = 2'b10;
                m.alu = '1; m.res = '1; e.res = 2'b10;
            end
            MEMADR: begin
                m.srca = 1; m.srcb = '1; e.srcb = 2'b01; m.alu = '1;
            end
            MEMRD: begin
                e.req = 1; m.adr = 1; e.adr = 1;
            end
            MEMWB: begin
                m.res = '1; e.res = 2'b01; e.regw = 1; e.pcw = rd15;
            end
            MEMWR: begin
                e.req = 1; m.adr = 1; e.adr = 1; e.memw = 1;
            end
            EXECR, EXECI: begin
                m.srca = 1; m.srcb = '1; e.srcb = (s == EXECI) ? 2'b01 : 2'b00;
                if (ok) begin m.alu = '1; e.alu = alu; end
                e.shf = mv;
            end
            ALUWB: begin
                m.res = '1; e.res = 2'b00; e.regw = !nw; e.pcw = !nw && rd15;
            end
            BRANCH: begin
                m.srca = 1; m.srcb = '1; e.srcb = 2'b01; m.alu = '1;
                m.res = '1; e.res = 2'b10; e.pcw = 1;
            end
            default: ;
        endcase
    endtask

    task automatic build_plan(input logic [19:0] ins, input logic [3:0] f);
        plan.delete();
        plan.push_back(FETCH);
        plan.push_back(DECODE);
        if (cond_ok(ins[19:16], f)) begin
            case (ins[15:14])
                2'b01: begin
                    plan.push_back(MEMADR);
                    if (ins[8]) begin plan.push_back(MEMRD); plan.push_back(MEMWB); end
                    else plan.push_back(MEMWR);
                end
                2'b10: plan.push_back(BRANCH);
                2'b00: begin
                    plan.push_back(ins[13] ? EXECI : EXECR);
                    plan.push_back(ALUWB);
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_obs(input string tag, input obs_t e, input obs_t m);
        obs_t o;
        o = (sel == 0) ? obs0 : obs1;
        total++;
        assert ((o & m) === (e & m)) else begin
            bad++;
            $error("FAIL %s: got %h want %h mask %h", tag, o & m, e & m, m);
        end
    endtask

    task automatic check_flags(input string tag);
        logic [3:0] got;
        got = (sel == 0) ? dut.flags_q : dut_ns.flags_q;
        total++;
        assert (got === mflags[sel]) else begin
            bad++;
            $error("FAIL %s:flags got %b want %b", tag, got, mflags[sel]);
        end
    endtask

    task automatic cycle(input state_t s, input logic [19:0] ins, input logic rdy,
                         input string tag);
        obs_t e, m;
        @(negedge clk);
        expect_for(s, ins, rdy, (sel == 0), e, m);
        check_obs($sformatf("%s:%s", tag, s.name()), e, m);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [19:0] ins, input logic [3:0] af, input int wf,
                             input int wm, input string tag);
        logic [3:0] f;
        logic       ok, nw, cv, mv;
        logic [1:0] alu;
        int         waits;
        bit         memst;
        instr = ins;
        aluflags = af;
        build_plan(ins, mflags[sel]);
        foreach (plan[i]) begin
            memst = (plan[i] == FETCH) || (plan[i] == MEMRD) || (plan[i] == MEMWR);
            waits = 0;
            if (sel == 0 && memst) waits = (plan[i] == FETCH) ? wf : wm;
            for (int k = 0; k <= waits; k++) begin
                if (sel == 0) mr0 = memst ? (k == waits) : 1'($urandom);
                else mr0 = 1'($urandom);
                mr1 = 1'($urandom);
                cycle(plan[i], ins, (k == waits), tag);
            end
            if (plan[i] == EXECR || plan[i] == EXECI) begin
                cmd_info(ins[12:9], (sel == 0), ok, nw, cv, mv, alu);
                f = mflags[sel];
                if (ins[8] && ok) begin
                    f[3:2] = af[3:2];
                    if (cv) f[1:0] = af[1:0];
                end
                mflags[sel] = f;
            end
        end
        check_flags(tag);
    endtask

    task automatic do_reset(input string tag);
        obs_t e, m;
        int   keep;
        @(posedge clk);
        #1;
        reset = 0;
        mr0 = 1;
        mr1 = 1;
        #2;
        keep = sel;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            expect_for(FETCH, instr, 1'b1, (d == 0), e, m);
            e.req = 0; e.pcw = 0; e.irw = 0;
            check_obs({tag, ":rst"}, e, m);
        end
        sel = keep;
        @(posedge clk);
        #1;
        reset = 1;
        mflags[0] = 4'b0000;
        mflags[1] = 4'b0000;
    endtask

    function automatic logic [19:0] rand_instr();
        logic [3:0] cc, rd, lo;
        logic [1:0] op;
        logic [5:0] fn;
        cc = ($urandom_range(0, 2) == 0) ? 4'he : 4'($urandom);
        op = 2'($urandom);
        fn = 6'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 5))
                0: fn[4:1] = 4'b0100;
                1: fn[4:1] = 4'b0010;
                2: fn[4:1] = 4'b0000;
                3: fn[4:1] = 4'b1100;
                4: fn[4:1] = 4'b1010;
                default: fn[4:1] = 4'b1101;
            endcase
        end
        rd = ($urandom_range(0, 4) == 0) ? 4'hf : 4'($urandom);
        lo = 4'($urandom);
        return {cc, op, fn, rd, lo};
    endfunction

    obs_t e, m;

    initial begin
        mflags[0] = 4'b0000;
        mflags[1] = 4'b0000;
        sel = 0;
        do_reset("init");
        check_flags("init");

        // Directed steps on the handshake/shift-enabled controller
        run_instr(20'hE2802, 4'b0000, 0, 0, "add");
        run_instr(20'hE5901, 4'b0000, 0, 2, "ldr");
        run_instr(20'hE2500, 4'b0100, 0, 0, "subs");
        run_instr(20'h0A000, 4'b1111, 1, 0, "beq");
        run_instr(20'h1A000, 4'b0000, 0, 0, "bne");
        run_instr(20'hE3500, 4'b1000, 0, 0, "cmp");

        // Store stalled in MEMWR, then reset mid-access
        instr = 20'hE5801;
        aluflags = 4'b0000;
        mr0 = 1;
        cycle(FETCH, instr, 1'b1, "str");
        cycle(DECODE, instr, 1'b1, "str");
        cycle(MEMADR, instr, 1'b1, "str");
        mr0 = 0;
        @(negedge clk);
        expect_for(MEMWR, instr, 1'b0, 1'b1, e, m);
        check_obs("str:MEMWR", e, m);
        #2;
        reset = 0;
        #1;
        expect_for(FETCH, instr, 1'b0, 1'b1, e, m);
        e.req = 0; e.pcw = 0; e.irw = 0;
        check_obs("str:abort", e, m);
        @(posedge clk);
        #1;
        reset = 1;
        mflags[0] = 4'b0000;
        mflags[1] = 4'b0000;
        check_flags("str");

        run_instr(20'hE1B10, 4'b1010, 0, 0, "movs");

        for (int i = 0; i < 80; i++) begin
            run_instr(rand_instr(), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                      $sformatf("r0_%0d", i));
        end

        // Controller built without handshake or shifter
        sel = 1;
        do_reset("ns");
        run_instr(20'hE1B10, 4'b1111, 0, 0, "ns_movs");
        for (int i = 0; i < 40; i++) begin
            run_instr(rand_instr(), 4'($urandom), 0, 0, $sformatf("r1_%0d", i));
        end
        instr = 20'hE2802;
        mr1 = 0;
        cycle(FETCH, instr, 1'b1, "ns_noready");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
